// File: rtl/regs_pkg.sv
// ---------------------------------------------------------------------------
// regs_pkg -- constants shared by the 32x32 register bank and its neighbours.
//
// Contents:
//   REGS_AW        register address width
//   REGS_DW        register data width
//   REGS_NUM       number of architectural registers
//   REGS_ZERO_ADDR address of r0 (hardwired when REGS_ARB_ZERO_EN is defined)
//   REGS_CNT_MAX   saturation value for 32-bit performance counters
// ---------------------------------------------------------------------------
package regs_pkg;

    localparam int REGS_AW  = 5;
    localparam int REGS_DW  = 32;
    localparam int REGS_NUM = 32;

    localparam logic [REGS_AW-1:0] REGS_ZERO_ADDR = '0;

    localparam logic [31:0] REGS_CNT_MAX = 32'hFFFF_FFFF;

endpackage : regs_pkg

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker -- combinational round-robin selector.
//
// Searches req starting at index ptr and wrapping modulo NREQ; the first set
// bit wins.
//
// Parameters:
//   NREQ     number of requesters (2..4)
// Ports:
//   req      in  NREQ        request vector (already gated by the caller)
//   ptr      in  PW          index with highest priority this cycle
//   gnt      out NREQ        one-hot grant, all-zero when req is all-zero
//   gnt_idx  out PW          encoded grant index (0 when nothing granted)
// ---------------------------------------------------------------------------
module rr_picker
    import regs_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    logic found;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = PW'(idx);
            end
        end
    end

endmodule : rr_picker

// File: rtl/regs_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wr_arbiter -- shares the register bank's single write port between
// NREQ requesters using valid/ready and round-robin priority. An accepted
// write appears on the bank write port one cycle later.
//
// Build option:
//   REGS_ARB_ZERO_EN  when defined, r0 is hardwired: writes to address 0 are
//                     accepted (and advance the pointer) but never reach the
//                     bank; bank_waddr/bank_wdata hold.
//
// Parameters:
//   NREQ  requesters (2..4), AW address width, DW data width
// Ports:
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous active-high reset
//   req_valid     in   NREQ     requester i holds a write
//   req_addr      in   NREQ*AW  packed addresses, slot i at [i*AW +: AW]
//   req_data      in   NREQ*DW  packed data, slot i at [i*DW +: DW]
//   req_ready     out  NREQ     one-hot grant (combinational)
//   bank_stall    in   1        bank cannot take a write this cycle
//   bank_we       out  1        registered bank write enable
//   bank_waddr    out  AW       registered bank write address
//   bank_wdata    out  DW       registered bank write data
//   conflict_cnt  out  32       saturating count of non-stalled cycles with
//                               two or more requests valid
// ---------------------------------------------------------------------------
module regs_wr_arbiter
    import regs_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REGS_AW,
    parameter int DW   = REGS_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              bank_stall,
    output logic              bank_we,
    output logic [AW-1:0]     bank_waddr,
    output logic [DW-1:0]     bank_wdata,
    output logic [31:0]       conflict_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            do_write;
    logic [2:0]      nvalid;
    logic            multi_valid;

    // Stall and reset suppress grants combinationally, so ready can never be
    // seen without valid and nothing is accepted in those cycles.
    assign eligible = (rst || bank_stall) ? '0 : req_valid;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

`ifdef REGS_ARB_ZERO_EN
    // r0 is hardwired: the handshake completes but the bank is not written.
    assign do_write = accept && (sel_addr != AW'(REGS_ZERO_ADDR));
`else
    assign do_write = accept;
`endif

    always_comb begin
        nvalid = '0;
        for (int k = 0; k < NREQ; k++) begin
            nvalid = nvalid + 3'(req_valid[k]);
        end
    end

    assign multi_valid = (nvalid >= 3'd2);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            bank_we      <= 1'b0;
            bank_waddr   <= '0;
            bank_wdata   <= '0;
            conflict_cnt <= '0;
        end else begin
            bank_we <= do_write;
            if (do_write) begin
                bank_waddr <= sel_addr;
                bank_wdata <= sel_data;
            end

            if (accept) begin
                rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end

            if (!bank_stall && multi_valid && (conflict_cnt != REGS_CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

endmodule : regs_wr_arbiter

// File: tb/tb_regs_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_wr_arbiter -- directed bench for regs_wr_arbiter (NREQ=2).
// Each stimulus step checks req_ready and conflict_cnt, and pushes the bank
// write it expects into a scoreboard; an independent monitor pops and compares
// every bank_we pulse. Build with REGS_ARB_ZERO_EN to match the RTL option.
// ---------------------------------------------------------------------------
module tb_regs_wr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              bank_stall;
    logic              bank_we;
    logic [AW-1:0]     bank_waddr;
    logic [DW-1:0]     bank_wdata;
    logic [31:0]       conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] sb[$];

    regs_wr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .bank_stall   (bank_stall),
        .bank_we      (bank_we),
        .bank_waddr   (bank_waddr),
        .bank_wdata   (bank_wdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, driven after the falling edge. conflict_cnt is
    // checked first (it reflects all earlier edges), then the new inputs are
    // applied and the combinational grant is checked.
    task automatic step(input string name, input logic r, input logic s,
                        input logic [1:0] v,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [1:0] exp_rdy, input logic [31:0] exp_cnt);
        @(negedge clk);
        check({name, "_cnt"}, 64'(conflict_cnt), 64'(exp_cnt));
        rst        = r;
        bank_stall = s;
        req_valid  = v;
        req_addr   = {a1, a0};
        req_data   = {d1, d0};
        #1;
        check({name, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy[0]) begin
`ifdef REGS_ARB_ZERO_EN
            if (a0 != '0) sb.push_back({a0, d0});
`else
            sb.push_back({a0, d0});
`endif
        end
        if (exp_rdy[1]) begin
`ifdef REGS_ARB_ZERO_EN
            if (a1 != '0) sb.push_back({a1, d1});
`else
            sb.push_back({a1, d1});
`endif
        end
    endtask

    // Scoreboard monitor: every bank_we pulse must match the oldest expected write.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bank_we === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bank_write_unexpected: got addr %h data %h expected no write",
                             bank_waddr, bank_wdata);
                end else begin
                    e = sb.pop_front();
                    check("bank_write", 64'({bank_waddr, bank_wdata}), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bank_stall = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        repeat (2) @(posedge clk);

        // Reset: grants gated even with both requesters valid.
        step("reset_gate", 1, 0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 2'b00, 32'd0);
        @(posedge clk); #1;
        check("reset_we",    64'(bank_we),    64'd0);
        check("reset_waddr", 64'(bank_waddr), 64'd0);
        check("reset_wdata", 64'(bank_wdata), 64'd0);

        // Single requesters.
        step("single0", 0, 0, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b01, 32'd0);
        step("single1", 0, 0, 2'b10, 5'd0, 32'h0, 5'd7, 32'h1111_1111, 2'b10, 32'd0);

        // Both valid for 6 cycles from rr_ptr=0: alternating grants.
        step("rr_c0", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b01, 32'd0);
        step("rr_c1", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b10, 32'd1);
        step("rr_c2", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b01, 32'd2);
        step("rr_c3", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b10, 32'd3);
        step("rr_c4", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b01, 32'd4);
        step("rr_c5", 0, 0, 2'b11, 5'd1, 32'hA0A0_A0A0, 5'd2, 32'hB1B1_B1B1, 2'b10, 32'd5);

        // Move pointer to 1, then stall with both valid: no grants, no counting.
        step("pre_stall", 0, 0, 2'b01, 5'd4, 32'hC4C4_C4C4, 5'd0, 32'h0, 2'b01, 32'd6);
        step("stall_c0", 0, 1, 2'b11, 5'd1, 32'hA1A1_A1A1, 5'd5, 32'hD5D5_D5D5, 2'b00, 32'd6);
        step("stall_c1", 0, 1, 2'b11, 5'd1, 32'hA1A1_A1A1, 5'd5, 32'hD5D5_D5D5, 2'b00, 32'd6);
        step("stall_c2", 0, 1, 2'b11, 5'd1, 32'hA1A1_A1A1, 5'd5, 32'hD5D5_D5D5, 2'b00, 32'd6);
        step("post_stall", 0, 0, 2'b11, 5'd1, 32'hA1A1_A1A1, 5'd5, 32'hD5D5_D5D5, 2'b10, 32'd6);

        // Write to r0, then the other requester must be next.
        step("zero_wr", 0, 0, 2'b01, 5'd0, 32'h1234_5678, 5'd0, 32'h0, 2'b01, 32'd7);
        step("after_zero", 0, 0, 2'b11, 5'd1, 32'hA2A2_A2A2, 5'd6, 32'hE6E6_E6E6, 2'b10, 32'd7);

        // Accept, then reset the next cycle.
        step("pre_rst", 0, 0, 2'b01, 5'd9, 32'h9999_9999, 5'd0, 32'h0, 2'b01, 32'd8);
        step("mid_rst", 1, 0, 2'b11, 5'd9, 32'h9999_9999, 5'd8, 32'h8888_8888, 2'b00, 32'd8);
        @(posedge clk); #1;
        check("mid_rst_we", 64'(bank_we), 64'd0);
        step("post_rst", 0, 0, 2'b11, 5'd10, 32'h0A0A_0A0A, 5'd11, 32'h0B0B_0B0B, 2'b01, 32'd0);

        // Saturation: preload near the top, then three conflicting cycles.
        @(posedge clk); #2;
        force dut.conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt;
        step("sat_c0", 0, 0, 2'b11, 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D, 2'b10, 32'hFFFF_FFFE);
        step("sat_c1", 0, 0, 2'b11, 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D, 2'b01, 32'hFFFF_FFFF);
        step("sat_c2", 0, 0, 2'b11, 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D, 2'b10, 32'hFFFF_FFFF);
        step("idle0", 0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 32'hFFFF_FFFF);
        step("idle1", 0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regs_wr_arbiter
